tx_msg_sequencer: RTL and testbench

//  Sequences a byte-stream source (character ROM with next-strobe) into the serial transmitter.

---
 rtl/tx_msg_sequencer.sv | 144 ++++++++++++++
 tb/tb_tx_msg_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_msg_sequencer.sv
// Steps a byte source into a UART TX: MSG_LEN bytes per message, GAP_CYCLES idle clocks between messages.
// Optional TX_CRLF_EN macro appends 8'h0D 8'h0A to every message.
module tx_msg_sequencer #(
    parameter int MSG_LEN    = 14,
    parameter int GAP_CYCLES = 1000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [7:0] i_src_data,
    output logic       o_src_next,
    output logic [7:0] o_tx_data,
    output logic       o_tx_stb,
    input  logic       i_tx_busy,
    output logic       o_busy,
    output logic       o_msg_done,
    output logic [2:0] o_dbg_state
);
    // Handshake: a byte transfers on any rising edge where o_tx_stb=1 and i_tx_busy=0;
    // o_tx_stb and o_tx_data hold unchanged until that edge.
    localparam int BW = $clog2(MSG_LEN + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(MSG_LEN - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SEND    = 3'd2,
        S_GAP     = 3'd3
`ifdef TX_CRLF_EN
        ,
        S_CR_LOAD = 3'd4,
        S_CR_SEND = 3'd5,
        S_LF_LOAD = 3'd6,
        S_LF_SEND = 3'd7
`endif
    } state_t;

    state_t          state_q;
    state_t          msg_end_d;
    logic [BW-1:0]   byte_cnt_q;
    logic [GW-1:0]   gap_cnt_q;
    logic [7:0]      tx_data_q;
    logic            tx_stb_q;
    logic            src_next_q;
    logic            msg_done_q;

    // Where to go once a message is fully accepted; a zero gap decides immediately.
    always_comb begin
        msg_end_d = S_GAP;
        if (GAP_CYCLES == 0) begin
            msg_end_d = i_enable ? S_LOAD : S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tx_data_q  <= 8'h00;
            tx_stb_q   <= 1'b0;
            src_next_q <= 1'b0;
            msg_done_q <= 1'b0;
        end else begin
            src_next_q <= 1'b0;
            msg_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_enable) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_data_q <= i_src_data;
                    tx_stb_q  <= 1'b1;
                    state_q   <= S_SEND;
                end
                S_SEND: begin
                    if (!i_tx_busy) begin
                        tx_stb_q   <= 1'b0;
                        src_next_q <= 1'b1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_q <= '0;
`ifdef TX_CRLF_EN
                            state_q    <= S_CR_LOAD;
`else
                            msg_done_q <= 1'b1;
                            state_q    <= msg_end_d;
`endif
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BW'(1);
                            state_q    <= S_LOAD;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == LAST_GAP) begin
                        gap_cnt_q <= '0;
                        state_q   <= i_enable ? S_LOAD : S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
`ifdef TX_CRLF_EN
                // Trailer bytes use the same handshake but never step the source.
                S_CR_LOAD: begin
                    tx_data_q <= 8'h0D;
                    tx_stb_q  <= 1'b1;
                    state_q   <= S_CR_SEND;
                end
                S_CR_SEND: begin
                    if (!i_tx_busy) begin
                        tx_stb_q <= 1'b0;
                        state_q  <= S_LF_LOAD;
                    end
                end
                S_LF_LOAD: begin
                    tx_data_q <= 8'h0A;
                    tx_stb_q  <= 1'b1;
                    state_q   <= S_LF_SEND;
                end
                S_LF_SEND: begin
                    if (!i_tx_busy) begin
                        tx_stb_q   <= 1'b0;
                        msg_done_q <= 1'b1;
                        state_q    <= msg_end_d;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_stb    = tx_stb_q;
    assign o_src_next  = src_next_q;
    assign o_msg_done  = msg_done_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_tx_msg_sequencer.sv
// Bench for tx_msg_sequencer: counting source, busy-cycle TX model and a message-level byte model.
// Build with TX_CRLF_EN defined to exercise the CR/LF trailer.
module tb_tx_msg_sequencer;
  localparam int GAP_CYCLES = 5;
`ifdef TX_CRLF_EN
  localparam int MSG_LEN = 2;
  localparam int PER     = MSG_LEN + 2;
`else
  localparam int MSG_LEN = 3;
  localparam int PER     = MSG_LEN;
`endif

  logic       clk;
  logic       i_reset;
  logic       i_enable;
  logic [7:0] i_src_data;
  logic       i_tx_busy;
  logic       o_src_next;
  logic [7:0] o_tx_data;
  logic       o_tx_stb;
  logic       o_busy;
  logic       o_msg_done;
  logic [2:0] o_dbg_state;

  tx_msg_sequencer #(.MSG_LEN(MSG_LEN), .GAP_CYCLES(GAP_CYCLES)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_src_data  (i_src_data),
    .o_src_next  (o_src_next),
    .o_tx_data   (o_tx_data),
    .o_tx_stb    (o_tx_stb),
    .i_tx_busy   (i_tx_busy),
    .o_busy      (o_busy),
    .o_msg_done  (o_msg_done),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  // ---------------- environment state / scoreboard ----------------
  int vectors;
  int miscompares;
  int cyc;
  int src_idx;
  int busy_cnt;
  int busy_len;
  bit force_busy;
  bit rand_busy;
  int n_next;
  int n_done;
  int viol;
  int low_run;
  bit prev_next;
  bit prev_done;
  logic [7:0] act_q[$];
  logic [7:0] exp_q[$];
  int low_q[$];

  // k-th byte the TX should receive after a reset: source bytes count up from 8'h41
  // across messages, with an optional CR LF after every MSG_LEN of them.
  function automatic logic [7:0] model_byte(int k);
    int m;
    int off;
    m = k / PER;
    off = k % PER;
    if (off < MSG_LEN) return 8'(8'h41 + m * MSG_LEN + off);
    return (off == MSG_LEN) ? 8'h0D : 8'h0A;
  endfunction

  // One clock: decides what the DUT sees at the coming edge, then updates the
  // source and TX models from outputs sampled at the falling edge.
  task automatic tick();
    bit acc;
    bit rst;
    logic [7:0] acc_data;
    acc = o_tx_stb && !i_tx_busy && !i_reset;
    acc_data = o_tx_data;
    rst = i_reset;
    @(negedge clk);
    cyc++;
    if (acc) begin
      act_q.push_back(acc_data);
      busy_cnt = rand_busy ? int'($urandom_range(0, 4)) : busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    if (rst) src_idx = 0;
    else if (o_src_next) src_idx++;
    if (o_src_next) n_next++;
    if (o_msg_done) n_done++;
    if ((o_src_next && prev_next) || (o_msg_done && prev_done)) viol++;
    prev_next = o_src_next;
    prev_done = o_msg_done;
    if (!o_tx_stb) begin
      low_run++;
    end else if (low_run > 0) begin
      low_q.push_back(low_run);
      low_run = 0;
    end
    i_src_data = 8'(8'h41 + src_idx);
    i_tx_busy = force_busy || (busy_cnt > 0);
  endtask

  task automatic clear_stats();
    act_q.delete();
    low_q.delete();
    n_next = 0;
    n_done = 0;
    viol = 0;
    low_run = 0;
    prev_next = 1'b0;
    prev_done = 1'b0;
  endtask

  task automatic apply_reset(input bit en);
    i_reset = 1'b1;
    i_enable = en;
    force_busy = 1'b0;
    repeat (3) tick();
    busy_cnt = 0;
    clear_stats();
    i_reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_reset = 1'b1;
    i_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if ({o_tx_stb, o_src_next, o_busy, o_msg_done} !== 4'b0000 || o_tx_data !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_hold cyc%0d: stb=%b next=%b busy=%b done=%b data=%h, required all 0",
                 i, o_tx_stb, o_src_next, o_busy, o_msg_done, o_tx_data);
      end
    end
  endtask

  task automatic test_message();
    int b;
    busy_len = 10;
    rand_busy = 1'b0;
    apply_reset(1'b1);
    tick();
    vectors++;
    if (o_tx_stb !== 1'b0) begin
      miscompares++;
      $display("FAIL start_latency_edge1: stb=%b, required 0", o_tx_stb);
    end
    tick();
    vectors++;
    if (o_tx_stb !== 1'b1) begin
      miscompares++;
      $display("FAIL start_latency_edge2: stb=%b, required 1", o_tx_stb);
    end
    b = 600;
    while (n_done == 0 && b > 0) begin tick(); b--; end
    vectors++;
    if (n_done == 0) begin
      miscompares++;
      $display("FAIL msg_timeout: no o_msg_done within budget");
      return;
    end
    vectors++;
    if (act_q.size() != PER || n_next != MSG_LEN) begin
      miscompares++;
      $display("FAIL msg_counts: accepts=%0d src_next=%0d at done, required %0d and %0d",
               act_q.size(), n_next, PER, MSG_LEN);
    end
    b = 600;
    while (act_q.size() <= PER && b > 0) begin tick(); b--; end
    vectors++;
    if (act_q.size() <= PER || low_q.size() < PER + 1) begin
      miscompares++;
      $display("FAIL msg2_timeout: accepts=%0d stb_rises=%0d, required >%0d", act_q.size(), low_q.size(), PER);
      return;
    end
    for (int k = 0; k <= PER; k++) begin
      vectors++;
      if (act_q[k] !== model_byte(k)) begin
        miscompares++;
        $display("FAIL msg_byte%0d: got %h, required %h", k, act_q[k], model_byte(k));
      end
    end
    for (int k = 1; k <= PER; k++) begin
      vectors++;
      if (k % PER == 0) begin
        if (low_q[k] < GAP_CYCLES) begin
          miscompares++;
          $display("FAIL msg_gap: stb low %0d clk, required >= %0d", low_q[k], GAP_CYCLES);
        end
      end else if (low_q[k] != 1) begin
        miscompares++;
        $display("FAIL accept_to_stb byte%0d: stb low %0d clk, required 1", k, low_q[k]);
      end
    end
  endtask

  task automatic test_busy_hold();
    int b;
    logic [7:0] held;
    busy_len = 0;
    rand_busy = 1'b0;
    apply_reset(1'b1);
    force_busy = 1'b1;
    b = 20;
    while (!o_tx_stb && b > 0) begin tick(); b--; end
    held = o_tx_data;
    vectors++;
    if (o_tx_stb !== 1'b1 || held !== model_byte(0)) begin
      miscompares++;
      $display("FAIL busy_first: stb=%b data=%h, required 1 and %h", o_tx_stb, held, model_byte(0));
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (o_tx_stb !== 1'b1 || o_tx_data !== held || o_src_next !== 1'b0 || act_q.size() != 0) begin
        miscompares++;
        $display("FAIL busy_freeze cyc%0d: stb=%b data=%h next=%b accepts=%0d, required 1 %h 0 0",
                 i, o_tx_stb, o_tx_data, o_src_next, act_q.size(), held);
      end
    end
    force_busy = 1'b0;
    tick();
    tick();
    vectors++;
    if (act_q.size() != 1 || o_src_next !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_release: accepts=%0d next=%b, required 1 and 1", act_q.size(), o_src_next);
    end
  endtask

  task automatic test_enable_drop();
    int b;
    int done_cyc;
    busy_len = 3;
    rand_busy = 1'b0;
    apply_reset(1'b1);
    b = 100;
    while (act_q.size() == 0 && b > 0) begin tick(); b--; end
    i_enable = 1'b0;
    done_cyc = -1;
    b = 400;
    while (o_busy && b > 0) begin
      tick();
      b--;
      if (o_msg_done) done_cyc = cyc;
    end
    vectors++;
    if (o_busy !== 1'b0 || done_cyc < 0) begin
      miscompares++;
      $display("FAIL drop_timeout: busy=%b done_seen=%0d, required 0 and seen", o_busy, done_cyc >= 0);
      return;
    end
    vectors++;
    if (act_q.size() != PER || n_done != 1) begin
      miscompares++;
      $display("FAIL drop_counts: accepts=%0d done=%0d, required %0d and 1", act_q.size(), n_done, PER);
    end
    for (int k = 0; k < act_q.size() && k < PER; k++) begin
      vectors++;
      if (act_q[k] !== model_byte(k)) begin
        miscompares++;
        $display("FAIL drop_byte%0d: got %h, required %h", k, act_q[k], model_byte(k));
      end
    end
    vectors++;
    if (cyc - done_cyc != GAP_CYCLES) begin
      miscompares++;
      $display("FAIL drop_gap: idle after %0d clk, required %0d", cyc - done_cyc, GAP_CYCLES);
    end
    repeat (30) tick();
    vectors++;
    if (o_busy !== 1'b0 || act_q.size() != PER) begin
      miscompares++;
      $display("FAIL drop_stays_idle: busy=%b accepts=%0d, required 0 and %0d", o_busy, act_q.size(), PER);
    end
  endtask

  task automatic test_reset_mid_send();
    int b;
    busy_len = 0;
    rand_busy = 1'b0;
    apply_reset(1'b1);
    b = 50;
    while (act_q.size() == 0 && b > 0) begin tick(); b--; end
    force_busy = 1'b1;
    b = 50;
    while (!o_tx_stb && b > 0) begin tick(); b--; end
    vectors++;
    if (o_tx_stb !== 1'b1 || act_q.size() != 1) begin
      miscompares++;
      $display("FAIL rst_setup: stb=%b accepts=%0d, required 1 and 1", o_tx_stb, act_q.size());
    end
    i_reset = 1'b1;
    tick();
    vectors++;
    if (o_tx_stb !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_in_send: stb=%b busy=%b, required 0 and 0", o_tx_stb, o_busy);
    end
    i_reset = 1'b0;
    force_busy = 1'b0;
    busy_len = 2;
    busy_cnt = 0;
    clear_stats();
    b = 300;
    while (n_done == 0 && b > 0) begin tick(); b--; end
    vectors++;
    if (n_done != 1 || act_q.size() != PER) begin
      miscompares++;
      $display("FAIL rst_restart: done=%0d accepts=%0d, required 1 and %0d", n_done, act_q.size(), PER);
    end
    for (int k = 0; k < act_q.size() && k < PER; k++) begin
      vectors++;
      if (act_q[k] !== model_byte(k)) begin
        miscompares++;
        $display("FAIL rst_byte%0d: got %h, required %h", k, act_q[k], model_byte(k));
      end
    end
  endtask

  task automatic test_random_busy();
    int b;
    logic [7:0] exp_b;
    rand_busy = 1'b1;
    apply_reset(1'b1);
    exp_q.delete();
    for (int k = 0; k < 4 * PER; k++) exp_q.push_back(model_byte(k));
    b = 3000;
    while (act_q.size() < 4 * PER && b > 0) begin
      tick();
      b--;
    end
    vectors++;
    if (act_q.size() != 4 * PER || n_done != 4 || n_next != 4 * MSG_LEN) begin
      miscompares++;
      $display("FAIL rand_counts: accepts=%0d done=%0d next=%0d, required %0d 4 %0d",
               act_q.size(), n_done, n_next, 4 * PER, 4 * MSG_LEN);
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      vectors++;
      if (act_q[0] !== exp_b) begin
        miscompares++;
        $display("FAIL rand_byte: got %h, required %h", act_q[0], exp_b);
      end
      void'(act_q.pop_front());
    end
    vectors++;
    if (viol != 0) begin
      miscompares++;
      $display("FAIL pulse_width: %0d back-to-back pulses on o_src_next/o_msg_done, required 0", viol);
    end
    rand_busy = 1'b0;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    src_idx = 0;
    busy_cnt = 0;
    busy_len = 0;
    force_busy = 1'b0;
    rand_busy = 1'b0;
    i_reset = 1'b1;
    i_enable = 1'b0;
    i_tx_busy = 1'b0;
    i_src_data = 8'h41;
    clear_stats();
    test_reset();
    test_message();
    test_busy_hold();
    test_enable_drop();
    test_reset_mid_send();
    test_random_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
